// File: rtl/linebuf_seq_ctrl.sv
// linebuf_seq_ctrl
// Sequencer for a cascade of ROWS line FIFOs that builds a (ROWS+1)-line
// vertical window over a raster frame.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       frame start pulse, honoured only while idle
//   width       pixels per line, captured at start
//   height      lines per frame, captured at start
//   pix_valid   upstream pixel strobe
//   pix_ready   pixel can be accepted (FILL/RUN, combinational)
//   fifo_clken  clock enable shared by all line FIFOs (combinational)
//   fifo_enable read-enable qualifier for the FIFOs, high in RUN
//   fifo_rst_n  active-low re-arm reset for the FIFOs, low in DONE
//   col, row    position counters of the accepted pixel stream
//   win_valid   window output qualifier, one cycle after each RUN accept
//   frame_done  one-cycle end-of-frame pulse
//   busy        sequencer is not idle
//   cfg_err     one-cycle pulse on a start with an illegal geometry
module linebuf_seq_ctrl #(
    parameter int AWIDTH = 11,
    parameter int MAXW   = 1936,
    parameter int ROWS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] width,
    input  logic [AWIDTH-1:0] height,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              fifo_clken,
    output logic              fifo_enable,
    output logic              fifo_rst_n,
    output logic [AWIDTH-1:0] col,
    output logic [AWIDTH-1:0] row,
    output logic              win_valid,
    output logic              frame_done,
    output logic              busy,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AWIDTH-1:0] ZERO_C    = '0;
    localparam logic [AWIDTH-1:0] ONE_C     = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] TWO_C     = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] MAXW_C    = AWIDTH'(MAXW);
    localparam logic [AWIDTH-1:0] ROWS_C    = AWIDTH'(ROWS);
    localparam logic [AWIDTH-1:0] ROWS_M1_C = AWIDTH'(ROWS - 1);

    // A frame needs at least two pixels per line, must fit the FIFO depth,
    // and must have more lines than the FIFO cascade holds.
    function automatic logic cfg_legal(input logic [AWIDTH-1:0] w,
                                       input logic [AWIDTH-1:0] h);
        cfg_legal = (w >= TWO_C) && (w <= MAXW_C) && (h > ROWS_C);
    endfunction

    state_t            state_r, state_s;
    logic [AWIDTH-1:0] width_r, width_s;
    logic [AWIDTH-1:0] height_r, height_s;
    logic [AWIDTH-1:0] col_r, col_s;
    logic [AWIDTH-1:0] row_r, row_s;
    logic [AWIDTH-1:0] flush_cnt_r, flush_cnt_s;
    logic              fifo_enable_r, fifo_enable_s;
    logic              fifo_rst_n_r, fifo_rst_n_s;
    logic              win_valid_r, win_valid_s;
    logic              frame_done_r, frame_done_s;
    logic              busy_r, busy_s;
    logic              cfg_err_r, cfg_err_s;
    logic              accept_s;
    logic              col_last_s;
    logic              row_last_s;

    // Handshake and FIFO clock enable decoded straight from the state.
    always_comb begin
        pix_ready  = 1'b0;
        fifo_clken = 1'b0;
        case (state_r)
            FILL, RUN: begin
                pix_ready  = 1'b1;
                fifo_clken = pix_valid;
            end
            FLUSH: begin
                pix_ready  = 1'b0;
                fifo_clken = 1'b1;
            end
            default: begin
                pix_ready  = 1'b0;
                fifo_clken = 1'b0;
            end
        endcase
    end

    assign accept_s   = pix_valid & pix_ready;
    assign col_last_s = (col_r == (width_r - ONE_C));
    assign row_last_s = (row_r == (height_r - ONE_C));

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_s     = state_r;
        width_s     = width_r;
        height_s    = height_r;
        col_s       = col_r;
        row_s       = row_r;
        flush_cnt_s = flush_cnt_r;
        win_valid_s = 1'b0;
        cfg_err_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (cfg_legal(width, height)) begin
                        width_s  = width;
                        height_s = height;
                        col_s    = ZERO_C;
                        row_s    = ZERO_C;
                        state_s  = FILL;
                    end else begin
                        cfg_err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL, RUN: begin
                if (accept_s) begin
                    // Window data appears one cycle after a RUN accept,
                    // matching the FIFO read latency.
                    win_valid_s = (state_r == RUN);
                    if (col_last_s) begin
                        col_s = ZERO_C;
                        // Row wraps on the frame's final pixel so it never
                        // exceeds height-1.
                        if (row_last_s) begin
                            row_s = ZERO_C;
                        end else begin
                            row_s = row_r + ONE_C;
                        end
                        if ((state_r == FILL) && (row_r == ROWS_M1_C)) begin
                            state_s = RUN;
                        end else if ((state_r == RUN) && row_last_s) begin
                            state_s     = FLUSH;
                            flush_cnt_s = ZERO_C;
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        col_s = col_r + ONE_C;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            FLUSH: begin
                // Drain the cascade for exactly one line length.
                if (flush_cnt_r == (width_r - ONE_C)) begin
                    flush_cnt_s = ZERO_C;
                    state_s     = DONE;
                end else begin
                    flush_cnt_s = flush_cnt_r + ONE_C;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Registered status follows the state being entered so that each
        // output is valid for exactly the cycles spent in that state.
        fifo_enable_s = (state_s == RUN);
        fifo_rst_n_s  = (state_s != DONE);
        frame_done_s  = (state_s == DONE);
        busy_s        = (state_s != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            width_r       <= ZERO_C;
            height_r      <= ZERO_C;
            col_r         <= ZERO_C;
            row_r         <= ZERO_C;
            flush_cnt_r   <= ZERO_C;
            fifo_enable_r <= 1'b0;
            fifo_rst_n_r  <= 1'b0;
            win_valid_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            width_r       <= width_s;
            height_r      <= height_s;
            col_r         <= col_s;
            row_r         <= row_s;
            flush_cnt_r   <= flush_cnt_s;
            fifo_enable_r <= fifo_enable_s;
            fifo_rst_n_r  <= fifo_rst_n_s;
            win_valid_r   <= win_valid_s;
            frame_done_r  <= frame_done_s;
            busy_r        <= busy_s;
            cfg_err_r     <= cfg_err_s;
        end
    end

    assign col         = col_r;
    assign row         = row_r;
    assign fifo_enable = fifo_enable_r;
    assign fifo_rst_n  = fifo_rst_n_r;
    assign win_valid   = win_valid_r;
    assign frame_done  = frame_done_r;
    assign busy        = busy_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_linebuf_seq_ctrl.sv
// Self-checking bench for linebuf_seq_ctrl: directed scenarios, a constant
// vector table for configuration checks, and random stimulus, all compared
// against a frame-level model (accept count, flush count, phase).
module tb_linebuf_seq_ctrl;

    localparam int AW   = 11;
    localparam int MAXW = 1936;
    localparam int ROWS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] width = '0;
    logic [AW-1:0] height = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready, fifo_clken, fifo_enable, fifo_rst_n;
    logic [AW-1:0] col, row;
    logic          win_valid, frame_done, busy, cfg_err;

    linebuf_seq_ctrl #(.AWIDTH(AW), .MAXW(MAXW), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .fifo_clken(fifo_clken),
        .fifo_enable(fifo_enable), .fifo_rst_n(fifo_rst_n), .col(col), .row(row),
        .win_valid(win_valid), .frame_done(frame_done), .busy(busy),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 fill, 2 run, 3 flush, 4 done.
    int m_phase = 0, m_n = 0, m_w = 0, m_h = 0, m_f = 0;
    bit m_win = 0, m_err = 0, m_rstn = 0;

    int win_cnt, flush_clk, done_cnt, done_rst, wraps;
    int prev_col;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_w = 0; m_h = 0; m_f = 0;
        m_win = 0; m_err = 0; m_rstn = 0;
    endtask

    task automatic model_step(input bit s, input int w, input int h, input bit pv);
        bit acc;
        acc   = pv && (m_phase == 1 || m_phase == 2);
        m_win = acc && (m_phase == 2);
        m_err = 0;
        case (m_phase)
            0: if (s) begin
                   if (w >= 2 && w <= MAXW && h > ROWS) begin
                       m_w = w; m_h = h; m_n = 0; m_phase = 1;
                   end else m_err = 1;
               end
            1, 2: if (acc) begin
                   m_n++;
                   if (m_n == m_w * m_h) begin m_phase = 3; m_f = 0; end
                   else if (m_n == ROWS * m_w) m_phase = 2;
               end
            3: begin m_f++; if (m_f == m_w) m_phase = 4; end
            4: m_phase = 0;
            default: m_phase = 0;
        endcase
        m_rstn = (m_phase != 4);
    endtask

    function automatic int exp_col();
        return (m_w == 0) ? 0 : (m_n % m_w);
    endfunction

    function automatic int exp_row();
        return (m_w == 0) ? 0 : ((m_n / m_w) % m_h);
    endfunction

    task automatic check_regs();
        chk("col", col, exp_col());
        chk("row", row, exp_row());
        chk("fifo_enable", fifo_enable, m_phase == 2);
        chk("win_valid", win_valid, m_win);
        chk("frame_done", frame_done, m_phase == 4);
        chk("busy", busy, m_phase != 0);
        chk("fifo_rst_n", fifo_rst_n, m_rstn);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_fifo_enable"}, fifo_enable, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fifo_rst_n"}, fifo_rst_n, 0);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_fifo_clken"}, fifo_clken, 0);
    endtask

    // One clock: drive at negedge, check combinational outputs, then check
    // registered outputs just after the rising edge.
    task automatic cycle(input bit s, input int w, input int h, input bit pv);
        bit acc;
        @(negedge clk);
        start = s; width = AW'(w); height = AW'(h); pix_valid = pv;
        #1;
        acc = pv && (m_phase == 1 || m_phase == 2);
        chk("pix_ready", pix_ready, m_phase == 1 || m_phase == 2);
        chk("fifo_clken", fifo_clken, acc || m_phase == 3);
        if (m_phase == 3 && fifo_clken) flush_clk++;
        prev_col = col;
        @(posedge clk);
        model_step(s, w, h, pv);
        #1;
        check_regs();
        if (win_valid) win_cnt++;
        if (frame_done) done_cnt++;
        if (frame_done && !fifo_rst_n) done_rst++;
        if (m_w > 0 && prev_col == m_w - 1 && col == 0 && prev_col != 0) wraps++;
    endtask

    task automatic clear_counts();
        win_cnt = 0; flush_clk = 0; done_cnt = 0; done_rst = 0; wraps = 0;
    endtask

    // Complete a frame already in progress, bounded.
    task automatic finish_frame(input int w, input int h);
        int guard = 0;
        while (m_phase != 0 && guard < 20000) begin
            cycle(0, w, h, 1);
            guard++;
        end
        if (guard >= 20000) begin
            total++; bad++;
            $display("FAIL frame_timeout: still busy after %0d cycles", guard);
        end
    endtask

    task automatic run_frame(input int w, input int h, input int stall_col,
                             input bit mid_start);
        int  guard = 0;
        bit  stalled = 0;
        bit  started_mid = 0;
        clear_counts();
        cycle(1, w, h, 0);
        chk("frame_started", busy, 1);
        while (m_phase != 0 && guard < 20000) begin
            if (stall_col >= 0 && !stalled && m_phase == 1 && (m_n % w) == stall_col) begin
                stalled = 1;
                repeat (3) cycle(0, w, h, 0);
            end else if (mid_start && !started_mid && m_phase == 2) begin
                started_mid = 1;
                cycle(1, 8, h, 1);
            end else begin
                cycle(0, w, h, 1);
            end
            guard++;
        end
        if (guard >= 20000) begin
            total++; bad++;
            $display("FAIL frame_timeout: still busy after %0d cycles", guard);
        end
        chk("win_pulses", win_cnt, (h - ROWS) * w);
        chk("flush_clken_cycles", flush_clk, w);
        chk("frame_done_pulses", done_cnt, 1);
        chk("done_with_fifo_rst", done_rst, 1);
        chk("col_wraps", wraps, h);
        chk("busy_after_frame", busy, 0);
    endtask

    typedef struct {
        bit s;
        int w;
        int h;
        bit pv;
        bit exp_err;
        bit exp_busy;
        int exp_col;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   g;

        vecs[0] = '{1'b1, 1,    4, 1'b0, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, 4,    4, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 1937, 4, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{1'b1, 4,    2, 1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b0, 4,    4, 1'b1, 1'b0, 1'b0, 0};
        vecs[5] = '{1'b1, 4,    3, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{1'b0, 4,    3, 1'b1, 1'b0, 1'b1, 1};
        vecs[7] = '{1'b0, 4,    3, 1'b0, 1'b0, 1'b1, 1};
        vecs[8] = '{1'b0, 4,    3, 1'b1, 1'b0, 1'b1, 2};

        // Power-on reset.
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step(0, 0, 0, 0);
        #1;
        check_regs();
        chk("fifo_rst_n_release", fifo_rst_n, 1);

        // Configuration table: illegal starts, then a short legal start.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].s, vecs[i].w, vecs[i].h, vecs[i].pv);
            chk($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_col", i), col, vecs[i].exp_col);
            chk($sformatf("vec%0d_no_clken_idle", i), fifo_clken & ~busy, 0);
        end
        finish_frame(4, 3);

        // Nominal, stall, start-while-busy.
        run_frame(4, 4, -1, 0);
        run_frame(4, 4, 2, 0);
        run_frame(4, 4, -1, 1);

        // Reset during RUN at row 3, col 1.
        clear_counts();
        cycle(1, 4, 4, 0);
        g = 0;
        while (!(m_phase == 2 && m_n == 13) && g < 100) begin
            cycle(0, 4, 4, 1);
            g++;
        end
        chk("reach_row3_col1", row * 16 + col, 3 * 16 + 1);
        @(negedge clk);
        #2;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("held_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("fifo_rst_n_before_clk", fifo_rst_n, 0);
        @(posedge clk);
        model_step(0, 4, 4, 0);
        #1;
        check_regs();
        chk("no_done_after_rst", done_cnt, 0);
        run_frame(4, 4, -1, 0);

        // Back-to-back maximum-width frames.
        run_frame(1936, 3, -1, 0);
        run_frame(1936, 3, -1, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 5) == 0), $urandom_range(0, 14),
                  $urandom_range(0, 7), ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
